ex_mem_pipeline_register: RTL

EX/MEM pipeline register for the five-stage MIPS core. It sits directly upstream of the data memory and drives its `mem_read`, `mem_write`, `load_mode`, `address` and `write_data` inputs from registered state. It supports stall and flush, and screens misaligned or illegal memory accesses so they never reach the memory. Faults are latched as an exception record for the hazard/exception unit. It also keeps load and store retirement counters.

---
 rtl/ex_mem_pipeline_register.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_pipeline_register.sv
// ---------------------------------------------------------------------------
// ex_mem_pipeline_register
//
// EX/MEM pipeline register for the five-stage MIPS core. It drives the data
// memory's enables, load mode, address and store data from registered state,
// so nothing reaches the memory combinationally from EX. Misaligned or illegal
// accesses are screened before they are registered: the instruction still
// occupies MEM (mem_valid = 1) but with every enable forced low, and the first
// such fault is latched as an exception record for the hazard/exception unit.
// Retired (accepted, non-faulting, valid) loads and stores are counted.
//
// Pipeline control contract: on each rising edge the update priority is
//   rst > flush > stall > load.
// flush inserts a bubble (all enables low, datapath fields held), stall holds
// every pipeline field and both counters, load copies the EX inputs. exc_ack
// is honoured on every non-reset edge, whatever the pipeline is doing.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall, flush             pipeline hold / bubble insertion
//   ex_*                     EX-stage instruction fields
//   exc_ack                  clears the pending exception
//   mem_valid .. write_data  MEM-stage instruction / data memory controls
//   mem_reg_write, mem_mem_to_reg, mem_write_reg   to MEM/WB
//   exc_pending, exc_addr, exc_pc, exc_is_store    exception record
//   load_count, store_count  retirement counters (wrap at 2^COUNT_W)
// ---------------------------------------------------------------------------
module ex_mem_pipeline_register #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [1:0]         ex_load_mode,
  input  logic [31:0]        ex_alu_result,
  input  logic [31:0]        ex_write_data,
  input  logic               ex_reg_write,
  input  logic               ex_mem_to_reg,
  input  logic [4:0]         ex_write_reg,
  input  logic [31:0]        ex_pc,
  input  logic               exc_ack,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         load_mode,
  output logic [31:0]        address,
  output logic [31:0]        write_data,
  output logic               mem_reg_write,
  output logic               mem_mem_to_reg,
  output logic [4:0]         mem_write_reg,
  output logic               exc_pending,
  output logic [31:0]        exc_addr,
  output logic [31:0]        exc_pc,
  output logic               exc_is_store,
  output logic [COUNT_W-1:0] load_count,
  output logic [COUNT_W-1:0] store_count
);

  logic               r_valid;
  logic               r_read;
  logic               r_write;
  logic [1:0]         r_load_mode;
  logic [31:0]        r_address;
  logic [31:0]        r_write_data;
  logic               r_reg_write;
  logic               r_mem_to_reg;
  logic [4:0]         r_write_reg;
  logic               r_exc_pending;
  logic [31:0]        r_exc_addr;
  logic [31:0]        r_exc_pc;
  logic               r_exc_is_store;
  logic [COUNT_W-1:0] r_load_count;
  logic [COUNT_W-1:0] r_store_count;

  logic w_fault;
  logic w_load;
  logic w_capture;
  logic w_count_load;
  logic w_count_store;

  // Fault screen on the EX inputs. Stores are always word stores; loads are
  // word (00), signed half (01) or unsigned half (10); mode 11 is illegal.
  always_comb begin
    w_fault = 1'b0;
    if (ex_valid) begin
      if (ex_mem_write && (ex_alu_result[1:0] != 2'b00)) begin
        w_fault = 1'b1;
      end
      if (ex_mem_read) begin
        case (ex_load_mode)
          2'b00:        if (ex_alu_result[1:0] != 2'b00) w_fault = 1'b1;
          2'b01, 2'b10: if (ex_alu_result[0]) w_fault = 1'b1;
          default:      w_fault = 1'b1;
        endcase
        if (ex_mem_write) begin
          w_fault = 1'b1;
        end
      end
    end
  end

  assign w_load        = !flush && !stall;
  // A new fault overwrites the record only if none is held, or if the held
  // one is being acknowledged on this very edge.
  assign w_capture     = w_load && w_fault && (!r_exc_pending || exc_ack);
  assign w_count_load  = w_load && ex_valid && !w_fault && ex_mem_read;
  assign w_count_store = w_load && ex_valid && !w_fault && ex_mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_load_mode    <= 2'b00;
      r_address      <= 32'd0;
      r_write_data   <= 32'd0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_write_reg    <= 5'd0;
      r_exc_pending  <= 1'b0;
      r_exc_addr     <= 32'd0;
      r_exc_pc       <= 32'd0;
      r_exc_is_store <= 1'b0;
      r_load_count   <= '0;
      r_store_count  <= '0;
    end else begin
      // Pipeline fields
      if (flush) begin
        r_valid      <= 1'b0;
        r_read       <= 1'b0;
        r_write      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end else if (!stall) begin
        r_valid      <= ex_valid;
        r_read       <= ex_valid && ex_mem_read   && !w_fault;
        r_write      <= ex_valid && ex_mem_write  && !w_fault;
        r_reg_write  <= ex_valid && ex_reg_write  && !w_fault;
        r_mem_to_reg <= ex_valid && ex_mem_to_reg && !w_fault;
        r_load_mode  <= ex_load_mode;
        r_address    <= ex_alu_result;
        r_write_data <= ex_write_data;
        r_write_reg  <= ex_write_reg;
      end

      // Retirement counters
      if (w_count_load) begin
        r_load_count <= r_load_count + COUNT_W'(1);
      end
      if (w_count_store) begin
        r_store_count <= r_store_count + COUNT_W'(1);
      end

      // Exception record: capture beats acknowledge
      if (w_capture) begin
        r_exc_pending  <= 1'b1;
        r_exc_addr     <= ex_alu_result;
        r_exc_pc       <= ex_pc;
        r_exc_is_store <= ex_mem_write;
      end else if (exc_ack) begin
        r_exc_pending  <= 1'b0;
      end
    end
  end

  assign mem_valid      = r_valid;
  assign mem_read       = r_read;
  assign mem_write      = r_write;
  assign load_mode      = r_load_mode;
  assign address        = r_address;
  assign write_data     = r_write_data;
  assign mem_reg_write  = r_reg_write;
  assign mem_mem_to_reg = r_mem_to_reg;
  assign mem_write_reg  = r_write_reg;
  assign exc_pending    = r_exc_pending;
  assign exc_addr       = r_exc_addr;
  assign exc_pc         = r_exc_pc;
  assign exc_is_store   = r_exc_is_store;
  assign load_count     = r_load_count;
  assign store_count    = r_store_count;

endmodule
